ram64_arbiter: RTL and testbench
================================

Name: ram64_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of a single 64x16 RAM.
- The RAM writes on the clk edge when load is high and reads combinationally.
- The arbiter serialises accesses from ports A and B, drives the RAM's address/in/load, and returns a one-cycle ack per transaction, plus registered read data for reads.
- It sits between two bus masters, such as the CPU data port and a loader/DMA, and one ram64 instance.

Parameters:
- ADDR_W, 6, RAM address width (64 words).
- DATA_W, 16, data word width.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- a_req  input  1  port A request; held high with a_we/a_addr/a_wdata stable until a_ack.
- a_we  input  1  port A write (1) / read (0).
- a_addr  input  ADDR_W  port A word address.
- a_wdata  input  DATA_W  port A write data.
- a_ack  output  1  port A transaction complete, one-cycle pulse.
- a_rdata  output  DATA_W  port A read data, valid when a_ack is high after a read; held until the next A read.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B.
- mem_address  output  ADDR_W  to RAM address.
- mem_in  output  DATA_W  to RAM in.
- mem_load  output  1  to RAM load.
- mem_out  input  DATA_W  from RAM out (combinational read).
- busy  output  1  high while in ACCESS state.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; a_ack=b_ack=0; a_rdata=b_rdata=0.
  - Latched addr/wdata/we = 0; mem_load=0; busy=0.
  - Round-robin pointer last=B, so A wins the first tie.
- FSM, two states: IDLE, ACCESS.
- IDLE:
  - A port is eligible if its req=1 and its ack=0 this cycle. The ack-high cycle masks that port so a held req is not double-served.
  - No eligible port: stay IDLE.
  - One eligible port: grant it.
  - Both eligible: grant the port not equal to last.
  - On grant, latch the winner's addr/wdata/we and id, then go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_address = latched addr; mem_in = latched wdata; mem_load = latched we.
  - At the closing edge: the RAM performs the write if we=1.
  - If we=0, the winner's rdata <= mem_out. The other port's rdata is unchanged; a write leaves rdata unchanged.
  - The winner's ack <= 1 for exactly one cycle; last <= winner id; state <= IDLE.
- mem_address and mem_in always reflect the latched registers. mem_load is 0 outside ACCESS.
- Latency: req sampled at edge N → ACCESS during cycle N+1 → ack high during cycle N+2. Back-to-back throughput is one access per 2 cycles.
- Requester rules:
  - Deassert req (or present the next request) in the ack cycle.
  - A req still high after the ack cycle is a new transaction.
- Requests arriving during ACCESS wait; there is no drop and no reordering beyond round-robin.
- Fairness: with both ports continuously requesting, grants alternate A, B, A, B…
- busy = (state==ACCESS).
- Reset asserted during ACCESS:
  - Transaction is aborted; no ack is issued.
  - mem_load drops combinationally.
  - Write completion is undefined only if reset coincides with the clock edge; the requester reissues.
- Addresses wrap naturally within ADDR_W; no range checking.

Test Plan:
1. Reset, then a_req=1, a_we=1, a_addr=5, a_wdata=16'hBEEF → mem_load=1, mem_address=5 for exactly one cycle; a_ack pulses 2 cycles after req sampled; b_ack stays 0.
2. After test 1, b_req read from addr 5 → b_ack pulse with b_rdata=16'hBEEF; a_rdata remains 0.
3. a_req and b_req held high together, reads of addr 1 (=1111) and 2 (=2222) → grants alternate A, B, A, B; acks never overlap; a_rdata=16'h1111, b_rdata=16'h2222.
4. a_req held high across its ack cycle with a_addr=63 → the next grant starts one cycle after the ack (no double-serve in the ack cycle); mem_address=63 wraps correctly.
5. Assert reset mid-ACCESS of a B write → mem_load falls immediately, no b_ack, state IDLE, pointer reset (A wins the next tie).
6. Idle for 10 cycles with no requests → mem_load=0, busy=0, acks 0, rdata registers unchanged.

Source files
------------

// File: rtl/ram64_arbiter.sv
// rtl/ram64_arbiter.sv - two-port round-robin arbiter and sequencer for a 64x16 RAM
// Serialises A/B requests into one-cycle RAM accesses with a one-cycle ack and registered read data.
module ram64_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;     // 0 = A, 1 = B
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic a_elig, b_elig, grant_valid, grant_id;

  // A port in its ack cycle is masked so a still-high req is not served twice.
  assign a_elig      = a_req & ~a_ack_q;
  assign b_elig      = b_req & ~b_ack_q;
  assign grant_valid = a_elig | b_elig;
  assign grant_id    = (a_elig & b_elig) ? ~last_q : b_elig;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d    = last_q;
    id_d      = id_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (state_q == IDLE) begin
      if (grant_valid) begin
        id_d    = grant_id;
        we_d    = grant_id ? b_we    : a_we;
        addr_d  = grant_id ? b_addr  : a_addr;
        wdata_d = grant_id ? b_wdata : a_wdata;
      end
    end else begin
      last_d = id_q;
      if (id_q) begin
        b_ack_d = 1'b1;
        if (!we_q) b_rdata_d = mem_out;
      end else begin
        a_ack_d = 1'b1;
        if (!we_q) a_rdata_d = mem_out;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      last_q    <= last_d;
      id_q      <= id_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign busy        = (state_q == ACCESS);
  assign mem_load    = busy & we_q;
  assign mem_address = addr_q;
  assign mem_in      = wdata_q;
  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;

endmodule

// File: tb/tb_ram64_arbiter.sv
// tb/tb_ram64_arbiter.sv - directed self-checking bench for ram64_arbiter
// A behavioural 64x16 RAM sits on the memory side; checks are taken on the falling edge.
module tb_ram64_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [5:0]  a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [5:0]  b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic        a_ack, b_ack, mem_load, busy;
  logic [15:0] a_rdata, b_rdata, mem_in, mem_out;
  logic [5:0]  mem_address;
  logic [15:0] ram [0:63];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;
  assign mem_out = ram[mem_address];

  ram64_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_in(mem_in), .mem_load(mem_load),
    .mem_out(mem_out), .busy(busy)
  );

  // Single-port transaction; caller is at a falling edge with the bus idle.
  task automatic txn(input logic is_b, input logic we, input logic [5:0] addr, input logic [15:0] wdata);
    if (is_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
    @(negedge clk);
    total++; if (busy !== 1'b1 || mem_address !== addr) begin bad++; $display("FAIL txn_access got busy=%b addr=%0d exp busy=1 addr=%0d", busy, mem_address, addr); end
    @(negedge clk);
    total++; if ((is_b ? b_ack : a_ack) !== 1'b1) begin bad++; $display("FAIL txn_ack port=%0d got=0 exp=1", is_b); end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got a=%b b=%b exp 0 0", a_ack, b_ack); end
    total++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata got a=%h b=%h exp 0 0", a_rdata, b_rdata); end
    total++; if (mem_load !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_ctl got load=%b busy=%b exp 0 0", mem_load, busy); end
    total++; if (mem_address !== 6'd0 || mem_in !== 16'h0) begin bad++; $display("FAIL reset_latch got addr=%0d in=%h exp 0 0", mem_address, mem_in); end
    reset = 1'b0;
  endtask

  task automatic test_write_a();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'd5; a_wdata = 16'hBEEF;
    @(negedge clk);
    total++; if (mem_load !== 1'b1 || mem_address !== 6'd5 || mem_in !== 16'hBEEF) begin bad++; $display("FAIL wr_access got load=%b addr=%0d in=%h exp 1 5 beef", mem_load, mem_address, mem_in); end
    total++; if (a_ack !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL wr_early got ack=%b busy=%b exp 0 1", a_ack, busy); end
    @(negedge clk);
    total++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin bad++; $display("FAIL wr_ack got a=%b b=%b exp 1 0", a_ack, b_ack); end
    total++; if (mem_load !== 1'b0) begin bad++; $display("FAIL wr_load_one_cycle got=%b exp=0", mem_load); end
    a_req = 1'b0;
    @(negedge clk);
    total++; if (a_ack !== 1'b0 || b_ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL wr_after got a=%b b=%b busy=%b exp 0 0 0", a_ack, b_ack, busy); end
  endtask

  task automatic test_read_b();
    txn(1'b1, 1'b0, 6'd5, 16'h0);
    total++; if (b_rdata !== 16'hBEEF) begin bad++; $display("FAIL rd_b_data got=%h exp=beef", b_rdata); end
    total++; if (a_rdata !== 16'h0) begin bad++; $display("FAIL rd_a_untouched got=%h exp=0", a_rdata); end
  endtask

  task automatic test_round_robin();
    txn(1'b0, 1'b1, 6'd1, 16'h1111);
    txn(1'b1, 1'b1, 6'd2, 16'h2222);
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd2;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++; if (a_ack !== (k == 2 || k == 6) || b_ack !== (k == 4 || k == 8)) begin bad++; $display("FAIL rr_acks k=%0d got a=%b b=%b", k, a_ack, b_ack); end
      if (k % 2 == 1) begin
        total++; if (busy !== 1'b1 || mem_address !== ((k % 4 == 1) ? 6'd1 : 6'd2)) begin bad++; $display("FAIL rr_grant k=%0d got busy=%b addr=%0d", k, busy, mem_address); end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    total++; if (a_rdata !== 16'h1111 || b_rdata !== 16'h2222) begin bad++; $display("FAIL rr_rdata got a=%h b=%h exp 1111 2222", a_rdata, b_rdata); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_stop got busy=%b exp 0", busy); end
  endtask

  task automatic test_held_req();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'd63; a_wdata = 16'h6363;
    @(negedge clk);
    total++; if (busy !== 1'b1 || mem_address !== 6'd63 || mem_load !== 1'b1) begin bad++; $display("FAIL held_first got busy=%b addr=%0d load=%b", busy, mem_address, mem_load); end
    @(negedge clk);
    total++; if (a_ack !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL held_ack got ack=%b busy=%b exp 1 0", a_ack, busy); end
    @(negedge clk);
    total++; if (a_ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL held_masked got ack=%b busy=%b exp 0 0", a_ack, busy); end
    @(negedge clk);
    total++; if (busy !== 1'b1 || mem_address !== 6'd63) begin bad++; $display("FAIL held_second got busy=%b addr=%0d exp 1 63", busy, mem_address); end
    @(negedge clk);
    total++; if (a_ack !== 1'b1) begin bad++; $display("FAIL held_ack2 got=%b exp=1", a_ack); end
    a_req = 1'b0;
    @(negedge clk);
    txn(1'b1, 1'b0, 6'd63, 16'h0);
    total++; if (b_rdata !== 16'h6363) begin bad++; $display("FAIL held_readback got=%h exp=6363", b_rdata); end
  endtask

  task automatic test_reset_mid_access();
    txn(1'b0, 1'b0, 6'd1, 16'h0);
    b_req = 1'b1; b_we = 1'b1; b_addr = 6'd10; b_wdata = 16'h1234;
    @(negedge clk);
    total++; if (busy !== 1'b1 || mem_load !== 1'b1) begin bad++; $display("FAIL rst_pre got busy=%b load=%b exp 1 1", busy, mem_load); end
    reset = 1'b1;
    #1;
    total++; if (mem_load !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_async got load=%b busy=%b exp 0 0", mem_load, busy); end
    total++; if (a_rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", a_rdata); end
    @(posedge clk); #1;
    total++; if (b_ack !== 1'b0) begin bad++; $display("FAIL rst_no_ack got=%b exp=0", b_ack); end
    @(negedge clk);
    reset = 1'b0; b_req = 1'b0;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd2;
    @(negedge clk);
    total++; if (busy !== 1'b1 || mem_address !== 6'd1) begin bad++; $display("FAIL rst_ptr got busy=%b addr=%0d exp 1 1", busy, mem_address); end
    @(negedge clk);
    total++; if (a_ack !== 1'b1 || a_rdata !== 16'h1111) begin bad++; $display("FAIL rst_a got ack=%b rdata=%h exp 1 1111", a_ack, a_rdata); end
    a_req = 1'b0;
    @(negedge clk);
    total++; if (mem_address !== 6'd2) begin bad++; $display("FAIL rst_b_grant got=%0d exp=2", mem_address); end
    @(negedge clk);
    total++; if (b_ack !== 1'b1 || b_rdata !== 16'h2222) begin bad++; $display("FAIL rst_b got ack=%b rdata=%h exp 1 2222", b_ack, b_rdata); end
    b_req = 1'b0;
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++; if (mem_load !== 1'b0 || busy !== 1'b0 || a_ack !== 1'b0 || b_ack !== 1'b0) begin bad++; $display("FAIL idle_ctl k=%0d got load=%b busy=%b a=%b b=%b", k, mem_load, busy, a_ack, b_ack); end
      total++; if (a_rdata !== 16'h1111 || b_rdata !== 16'h2222) begin bad++; $display("FAIL idle_rdata k=%0d got a=%h b=%h", k, a_rdata, b_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read_b();
    test_round_robin();
    test_held_req();
    test_reset_mid_access();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
